// File: rtl/mux4to1_rr_16bit.sv
// mux4to1_rr_16bit: 4-channel valid/ready merger into one registered slot, tagged with source index.
// Optional MUX4_FIXED_PRIORITY_EN replaces round-robin with fixed priority 0>1>2>3.
`default_nettype none

module mux4to1_rr_16bit #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] in1,
  input  logic [width-1:0] in2,
  input  logic [width-1:0] in3,
  input  logic [width-1:0] in4,
  input  logic [3:0]       in_valid,
  output logic [3:0]       in_ready,
  output logic [width-1:0] out,
  output logic [1:0]       out_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       xfer_cnt
);

  logic       load_en;
  logic       found;
  logic [1:0] grant;
  logic [1:0] idx;
  logic       accept;

  assign load_en = !out_valid | out_ready;

`ifdef MUX4_FIXED_PRIORITY_EN
  always_comb begin
    found = 1'b0;
    grant = 2'd0;
    idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = 2'(k);
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end
`else
  logic [1:0] last;

  // Search starts just after the last winner so every channel waits at most 3 grants.
  always_comb begin
    found = 1'b0;
    grant = 2'd0;
    idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last <= 2'd3;
    end else if (accept) begin
      last <= grant;
    end
  end
`endif

  always_comb begin
    in_ready = 4'b0000;
    if (!reset && load_en && found) begin
      in_ready[grant] = 1'b1;
    end
  end

  assign accept = |(in_ready & in_valid);

  always_ff @(posedge clk) begin
    if (reset) begin
      out       <= '0;
      out_sel   <= 2'd0;
      out_valid <= 1'b0;
      xfer_cnt  <= 8'd0;
    end else if (accept) begin
      case (grant)
        2'd0:    out <= in1;
        2'd1:    out <= in2;
        2'd2:    out <= in3;
        default: out <= in4;
      endcase
      out_sel   <= grant;
      out_valid <= 1'b1;
      xfer_cnt  <= xfer_cnt + 8'd1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mux4to1_rr_16bit.sv
// tb_mux4to1_rr_16bit: directed scenarios plus randomized traffic checked against a behavioural model.
`default_nettype none

module tb_mux4to1_rr_16bit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in1, in2, in3, in4;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [15:0] out;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  xfer_cnt;

  mux4to1_rr_16bit #(.width(16)) dut (
    .clk(clk), .reset(reset),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .in_valid(in_valid), .in_ready(in_ready),
    .out(out), .out_sel(out_sel), .out_valid(out_valid),
    .out_ready(out_ready), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Source-side state: pending flag and held data per channel.
  logic [3:0]  v;
  logic [15:0] d [4];

  // Reference model of the observable state.
  int m_valid, m_out, m_sel, m_last, m_cnt;
  logic [3:0] last_er;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Winner is the first pending channel after the previous winner, wrapping around.
  function automatic logic [3:0] pick(input logic [3:0] vv, input int lst);
    for (int k = 1; k <= 4; k++) begin
`ifdef MUX4_FIXED_PRIORITY_EN
      int ch = k - 1;
`else
      int ch = (lst + k) % 4;
`endif
      if (vv[ch]) return 4'(1 << ch);
    end
    return 4'b0000;
  endfunction

  task automatic step(input logic rst_i, input logic ordy);
    logic [3:0] er;
    @(negedge clk);
    reset = rst_i;
    out_ready = ordy;
    in_valid = v;
    in1 = d[0]; in2 = d[1]; in3 = d[2]; in4 = d[3];
    #1;
    if (rst_i || (m_valid != 0 && !ordy)) er = 4'b0000;
    else er = pick(v, m_last);
    chk("in_ready", {28'd0, in_ready}, {28'd0, er});
    last_er = er;
    if (rst_i) begin
      m_valid = 0; m_out = 0; m_sel = 0; m_cnt = 0; m_last = 3;
    end else if (er != 0) begin
      for (int i = 0; i < 4; i++) begin
        if (er[i]) begin
          m_out = d[i]; m_sel = i; m_last = i;
        end
      end
      m_valid = 1;
      m_cnt = (m_cnt + 1) % 256;
    end else if (ordy) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
    chk("out_valid", {31'd0, out_valid}, m_valid);
    chk("out", {16'd0, out}, m_out);
    chk("out_sel", {30'd0, out_sel}, m_sel);
    chk("xfer_cnt", {24'd0, xfer_cnt}, m_cnt);
    v = v & ~er;
  endtask

  initial begin
    int seq [8];
    reset = 1'b1; out_ready = 1'b0; in_valid = 4'b0;
    in1 = '0; in2 = '0; in3 = '0; in4 = '0;
    m_valid = 0; m_out = 0; m_sel = 0; m_last = 3; m_cnt = 0;
    for (int i = 0; i < 4; i++) d[i] = 16'(i + 1);

    // Reset held with every channel requesting.
    v = 4'b1111;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk("reset_in_ready", {28'd0, in_ready}, 32'd0);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);

    // Single channel 2.
    v = 4'b0100; d[2] = 16'hA5A5;
    step(1'b0, 1'b1);
    chk("single_in_ready", {28'd0, last_er}, 32'h4);
    chk("single_out", {16'd0, out}, 32'hA5A5);
    chk("single_sel", {30'd0, out_sel}, 32'd2);
    chk("single_cnt", {24'd0, xfer_cnt}, 32'd1);

    // Round-robin with all channels continuously valid.
    step(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) d[i] = 16'(i + 1);
    for (int k = 0; k < 8; k++) begin
      v = 4'b1111;
      step(1'b0, 1'b1);
      seq[k] = int'(out_sel);
    end
    for (int k = 0; k < 8; k++) begin
`ifdef MUX4_FIXED_PRIORITY_EN
      chk("rr_seq", seq[k], 0);
`else
      chk("rr_seq", seq[k], k % 4);
`endif
    end
    chk("rr_cnt", {24'd0, xfer_cnt}, 32'd8);

    // Backpressure: slot holds BEEF while channels 1 and 3 wait.
    step(1'b1, 1'b1);
    v = 4'b0001; d[0] = 16'hBEEF;
    step(1'b0, 1'b1);
    v = 4'b1010; d[1] = 16'h1111; d[3] = 16'h3333;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0);
      chk("bp_hold", {16'd0, out}, 32'hBEEF);
    end
    step(1'b0, 1'b1);
    chk("bp_rel1", {30'd0, out_sel}, 32'd1);
    step(1'b0, 1'b1);
    chk("bp_rel2", {30'd0, out_sel}, 32'd3);

    // Drain to idle: data stays, valid falls.
    step(1'b0, 1'b1);
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_out", {16'd0, out}, 32'h3333);

    // Mid-operation reset at count 37.
    step(1'b1, 1'b1);
    for (int k = 0; k < 37; k++) begin
      v = 4'b0001; d[0] = 16'(k);
      step(1'b0, 1'b1);
    end
    chk("pre_rst_cnt", {24'd0, xfer_cnt}, 32'd37);
    v = 4'b1111;
    step(1'b1, 1'b1);
    chk("midrst_cnt", {24'd0, xfer_cnt}, 32'd0);
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    v = 4'b1111;
    step(1'b0, 1'b1);
    chk("post_rst_grant", {30'd0, out_sel}, 32'd0);

    // Randomized traffic with random backpressure and occasional reset.
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!v[i] && ($urandom_range(1, 0) == 1)) begin
          v[i] = 1'b1;
          d[i] = 16'($urandom);
        end
      end
      step(($urandom_range(59, 0) == 0), ($urandom_range(9, 0) < 7));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
